// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier scheduler.
package mult_pkg;

   localparam int unsigned OpW   = 32;
   localparam int unsigned ProdW = 64;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/wallace32.sv
// Combinational 32x32 unsigned multiplier core.
module wallace32 (
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [63:0] prod
);

   // Sum of shifted partial-product rows; synthesis reduces this to an adder tree.
   always_comb begin
      prod = '0;
      for (int i = 0; i < 32; i++) begin
         if (B[i]) begin
            prod = prod + ({32'b0, A} << i);
         end
      end
   end

endmodule

// File: rtl/mult_sched.sv
// Two-requester round-robin scheduler in front of a single shared multiplier.
// Signed operands are converted to magnitudes, multiplied unsigned, and the
// product is negated when the operand signs differ.
module mult_sched
   import mult_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [OpW-1:0]   req0_a,
   input  logic [OpW-1:0]   req0_b,
   input  logic [OpW-1:0]   req1_a,
   input  logic [OpW-1:0]   req1_b,
   input  logic             req0_signed,
   input  logic             req1_signed,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ProdW-1:0] res_prod,
   output logic             res_id
);

   state_e           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [OpW-1:0]   a_q, a_d, b_q, b_d;
   logic             sgn_q, sgn_d, id_q, id_d;
   logic             res_valid_q, res_valid_d;
   logic             res_id_q, res_id_d;
   logic [ProdW-1:0] res_prod_q, res_prod_d;

   logic [NREQ-1:0]  valid, grant;
   logic             can_accept;
   logic [OpW-1:0]   mag_a, mag_b;
   logic [ProdW-1:0] mag_p, prod;
   logic             neg;

   // Grant: the slot is free in IDLE or when the held result retires this cycle.
   always_comb begin
      valid      = {req1_valid, req0_valid};
      can_accept = reset_n && ((state_q == StIdle) || ((state_q == StDone) && res_ready));
      grant      = '0;
      if (can_accept) begin
         if (&valid) begin
            grant = ptr_q ? 2'b10 : 2'b01;
         end else begin
            grant = valid;
         end
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // Sign-magnitude wrapper; 0x80000000 negates to itself, i.e. magnitude 2^31.
   always_comb begin
      mag_a = (sgn_q && a_q[OpW-1]) ? (-a_q) : a_q;
      mag_b = (sgn_q && b_q[OpW-1]) ? (-b_q) : b_q;
      neg   = sgn_q && (a_q[OpW-1] ^ b_q[OpW-1]);
      prod  = neg ? (-mag_p) : mag_p;
   end

   wallace32 u_mul (
      .A    (mag_a),
      .B    (mag_b),
      .prod (mag_p)
   );

   // Next-state: FSM progression, then operand capture on any grant.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      sgn_d       = sgn_q;
      id_d        = id_q;
      res_valid_d = res_valid_q;
      res_prod_d  = res_prod_q;
      res_id_d    = res_id_q;

      unique case (state_q)
         StCalc: begin
            res_prod_d  = prod;
            res_id_d    = id_q;
            res_valid_d = 1'b1;
            state_d     = StDone;
         end
         StDone: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A grant in DONE overrides the IDLE transition: retire and accept together.
      if (|grant) begin
         state_d = StCalc;
         ptr_d   = grant[0];
         id_d    = grant[1];
         a_d     = grant[1] ? req1_a : req0_a;
         b_d     = grant[1] ? req1_b : req0_b;
         sgn_d   = grant[1] ? req1_signed : req0_signed;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         ptr_q       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sgn_q       <= 1'b0;
         id_q        <= 1'b0;
         res_valid_q <= 1'b0;
         res_prod_q  <= '0;
         res_id_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sgn_q       <= sgn_d;
         id_q        <= id_d;
         res_valid_q <= res_valid_d;
         res_prod_q  <= res_prod_d;
         res_id_q    <= res_id_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_prod  = res_prod_q;
   assign res_id    = res_id_q;

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_mult_sched;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_signed, req1_signed;
   logic        res_valid, res_ready, res_id;
   logic [63:0] res_prod;

   int n_vec = 0;
   int n_err = 0;

   mult_sched #(.NREQ(2)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req0_valid  (req0_valid),
      .req1_valid  (req1_valid),
      .req0_ready  (req0_ready),
      .req1_ready  (req1_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req0_signed (req0_signed),
      .req1_signed (req1_signed),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_prod    (res_prod),
      .res_id      (res_id)
   );

   always #5 clock = ~clock;

   // Reference product from plain 64-bit arithmetic.
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      logic signed [63:0] sa, sb;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      if (s) return sa * sb;
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h7FFF_FFFF;
         4: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic quiet();
      req0_valid  = 1'b0;
      req1_valid  = 1'b0;
      req0_a      = $urandom;
      req0_b      = $urandom;
      req1_a      = $urandom;
      req1_b      = $urandom;
      req0_signed = 1'b0;
      req1_signed = 1'b0;
      res_ready   = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      quiet();
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      quiet();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      res_ready  = 1'b1;
      #1;
      tick();
      n_vec++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready: got %b/%b, required 0/0", req0_ready, req1_ready);
      end
      n_vec++;
      if (res_valid !== 1'b0 || res_prod !== 64'd0 || res_id !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got valid=%b prod=%h id=%b, required 0/0/0",
                  res_valid, res_prod, res_id);
      end
      // Pointer resets to requester 0, so it wins the first contested grant.
      reset_n = 1'b1;
      #1;
      n_vec++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release_grant: got %b/%b, required 1/0", req0_ready, req1_ready);
      end
      quiet();
   endtask

   task automatic test_unsigned();
      apply_reset();
      req0_valid  = 1'b1;
      req0_a      = 32'd100000;
      req0_b      = 32'd99999;
      req0_signed = 1'b0;
      res_ready   = 1'b1;
      #1;
      n_vec++;
      if (req0_ready !== 1'b1) begin
         n_err++;
         $display("FAIL unsigned_ready: got %b, required 1", req0_ready);
      end
      tick();
      req0_valid = 1'b0;
      req0_a     = $urandom;
      req0_b     = $urandom;
      n_vec++;
      if (res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL unsigned_early: res_valid=%b one edge after accept, required 0", res_valid);
      end
      tick();
      n_vec++;
      if (res_valid !== 1'b1 || res_prod !== 64'd9999900000 || res_id !== 1'b0) begin
         n_err++;
         $display("FAIL unsigned_result: got valid=%b prod=%0d id=%b, required 1/9999900000/0",
                  res_valid, res_prod, res_id);
      end
      tick();
      n_vec++;
      if (res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL unsigned_retire: res_valid=%b, required 0", res_valid);
      end
   endtask

   task automatic test_signed();
      logic [31:0] ta[3];
      logic [31:0] tb[3];
      logic [63:0] te[3];
      ta = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0000};
      tb = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFB};
      te = '{64'hFFFF_FFFF_FFFF_FFD6, 64'h4000_0000_0000_0000, 64'd0};
      apply_reset();
      res_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req1_valid  = 1'b1;
         req1_a      = ta[k];
         req1_b      = tb[k];
         req1_signed = 1'b1;
         #1;
         n_vec++;
         if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_err++;
            $display("FAIL signed_ready[%0d]: got %b/%b, required 0/1", k, req0_ready, req1_ready);
         end
         tick();
         req1_valid = 1'b0;
         tick();
         n_vec++;
         if (res_valid !== 1'b1 || res_prod !== te[k] || res_id !== 1'b1) begin
            n_err++;
            $display("FAIL signed_result[%0d]: got valid=%b prod=%h id=%b, required 1/%h/1",
                     k, res_valid, res_prod, res_id, te[k]);
         end
      end
      tick();
   endtask

   task automatic test_contention();
      logic [31:0] oa[2][4];
      logic [31:0] ob[2][4];
      logic        os[2][4];
      int          idx[2];
      int          grants[$];
      logic [63:0] exp_p[$];
      logic        exp_i[$];
      logic [63:0] e;
      logic        ei;
      int          got;
      apply_reset();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) begin
            oa[r][k] = rnd_operand();
            ob[r][k] = rnd_operand();
            os[r][k] = 1'($urandom);
         end
      end
      idx = '{0, 0};
      got = 0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         if (res_valid === 1'b1) begin
            n_vec++;
            e  = exp_p.pop_front();
            ei = exp_i.pop_front();
            if (res_prod !== e || res_id !== ei) begin
               n_err++;
               $display("FAIL contention_result[%0d]: got %h id %b, required %h id %b",
                        got, res_prod, res_id, e, ei);
            end
            got++;
         end
         res_ready   = 1'b1;
         req0_valid  = (idx[0] < 4);
         req1_valid  = (idx[1] < 4);
         req0_a      = (idx[0] < 4) ? oa[0][idx[0]] : 32'd0;
         req0_b      = (idx[0] < 4) ? ob[0][idx[0]] : 32'd0;
         req0_signed = (idx[0] < 4) ? os[0][idx[0]] : 1'b0;
         req1_a      = (idx[1] < 4) ? oa[1][idx[1]] : 32'd0;
         req1_b      = (idx[1] < 4) ? ob[1][idx[1]] : 32'd0;
         req1_signed = (idx[1] < 4) ? os[1][idx[1]] : 1'b0;
         #1;
         if (req0_ready === 1'b1 && req1_ready !== 1'b1) begin
            grants.push_back(0);
            exp_p.push_back(ref_mul(oa[0][idx[0]], ob[0][idx[0]], os[0][idx[0]]));
            exp_i.push_back(1'b0);
            idx[0]++;
         end else if (req1_ready === 1'b1 && req0_ready !== 1'b1) begin
            grants.push_back(1);
            exp_p.push_back(ref_mul(oa[1][idx[1]], ob[1][idx[1]], os[1][idx[1]]));
            exp_i.push_back(1'b1);
            idx[1]++;
         end
         tick();
      end
      quiet();
      n_vec++;
      if (got != 8 || grants.size() != 8) begin
         n_err++;
         $display("FAIL contention_count: got %0d grants %0d results, required 8/8",
                  grants.size(), got);
      end
      foreach (grants[i]) begin
         n_vec++;
         if (grants[i] != (i % 2)) begin
            n_err++;
            $display("FAIL contention_order[%0d]: got %0d, required %0d", i, grants[i], i % 2);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a1, b1, a0, b0;
      logic [63:0] held;
      apply_reset();
      a1 = rnd_operand();
      b1 = rnd_operand();
      a0 = rnd_operand();
      b0 = rnd_operand();
      req1_valid  = 1'b1;
      req1_a      = a1;
      req1_b      = b1;
      req1_signed = 1'b1;
      tick();
      req1_valid = 1'b0;
      tick();
      n_vec++;
      if (res_valid !== 1'b1 || res_prod !== ref_mul(a1, b1, 1'b1) || res_id !== 1'b1) begin
         n_err++;
         $display("FAIL bp_first: got valid=%b prod=%h id=%b, required 1/%h/1",
                  res_valid, res_prod, res_id, ref_mul(a1, b1, 1'b1));
      end
      held = res_prod;
      req0_valid  = 1'b1;
      req0_a      = a0;
      req0_b      = b0;
      req0_signed = 1'b0;
      for (int c = 0; c < 5; c++) begin
         req1_a = $urandom;
         #1;
         n_vec++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ready[%0d]: got %b/%b, required 0/0", c, req0_ready, req1_ready);
         end
         tick();
         n_vec++;
         if (res_valid !== 1'b1 || res_prod !== held || res_id !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: got valid=%b prod=%h id=%b, required 1/%h/1",
                     c, res_valid, res_prod, res_id, held);
         end
      end
      res_ready = 1'b1;
      #1;
      n_vec++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release_grant: got %b/%b, required 1/0", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0;
      n_vec++;
      if (res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_retire: res_valid=%b, required 0", res_valid);
      end
      tick();
      n_vec++;
      if (res_valid !== 1'b1 || res_prod !== ref_mul(a0, b0, 1'b0) || res_id !== 1'b0) begin
         n_err++;
         $display("FAIL bp_second: got valid=%b prod=%h id=%b, required 1/%h/0",
                  res_valid, res_prod, res_id, ref_mul(a0, b0, 1'b0));
      end
      tick();
   endtask

   task automatic test_reset_midop();
      logic seen;
      apply_reset();
      // Reset while the first operation is in CALC.
      req0_valid = 1'b1;
      res_ready  = 1'b1;
      tick();
      req0_valid = 1'b0;
      reset_n    = 1'b0;
      #1;
      req0_valid = 1'b1;
      #1;
      n_vec++;
      if (res_valid !== 1'b0 || res_prod !== 64'd0 || req0_ready !== 1'b0) begin
         n_err++;
         $display("FAIL midop_calc_reset: got valid=%b prod=%h ready=%b, required 0/0/0",
                  res_valid, res_prod, req0_ready);
      end
      req0_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      // Reset while a result is held in DONE.
      req0_valid = 1'b1;
      req0_a     = 32'd7;
      req0_b     = 32'd9;
      res_ready  = 1'b0;
      tick();
      req0_valid = 1'b0;
      tick();
      reset_n = 1'b0;
      #1;
      n_vec++;
      if (res_valid !== 1'b0 || res_prod !== 64'd0) begin
         n_err++;
         $display("FAIL midop_done_reset: got valid=%b prod=%h, required 0/0", res_valid, res_prod);
      end
      tick();
      reset_n   = 1'b1;
      res_ready = 1'b1;
      seen      = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (res_valid !== 1'b0) seen = 1'b1;
      end
      n_vec++;
      if (seen) begin
         n_err++;
         $display("FAIL midop_ghost: res_valid seen after reset, required none");
      end
      req1_valid  = 1'b1;
      req1_a      = 32'hFFFF_FFFD;
      req1_b      = 32'd5;
      req1_signed = 1'b1;
      tick();
      req1_valid = 1'b0;
      tick();
      n_vec++;
      if (res_valid !== 1'b1 || res_prod !== 64'hFFFF_FFFF_FFFF_FFF1 || res_id !== 1'b1) begin
         n_err++;
         $display("FAIL midop_recover: got valid=%b prod=%h id=%b, required 1/fffffffffffffff1/1",
                  res_valid, res_prod, res_id);
      end
      tick();
      quiet();
   endtask

   task automatic test_random();
      logic [63:0] exp_q[$];
      logic        exp_id_q[$];
      logic [31:0] pa[2];
      logic [31:0] pb[2];
      logic        ps[2];
      logic        pv[2];
      logic        mptr, g0, g1, exp_any, held, held_id, eid;
      logic [63:0] held_prod, e;
      int          outstanding, acc_iter, gid;
      apply_reset();
      mptr        = 1'b0;
      outstanding = 0;
      acc_iter    = -10;
      held        = 1'b0;
      held_prod   = '0;
      held_id     = 1'b0;
      pv          = '{1'b0, 1'b0};
      for (int it = 0; it < 1060; it++) begin
         // Result appears on the second edge counting the accepting edge.
         n_vec++;
         if (res_valid !== ((outstanding > 0) && (it >= acc_iter + 2))) begin
            n_err++;
            $display("FAIL rnd_valid[%0d]: got %b, outstanding %0d", it, res_valid, outstanding);
         end
         if (held) begin
            n_vec++;
            if (res_prod !== held_prod || res_id !== held_id) begin
               n_err++;
               $display("FAIL rnd_stable[%0d]: got %h/%b, required %h/%b",
                        it, res_prod, res_id, held_prod, held_id);
            end
         end
         for (int r = 0; r < 2; r++) begin
            if (!pv[r] && it < 1000 && $urandom_range(0, 99) < 50) begin
               pv[r] = 1'b1;
               pa[r] = rnd_operand();
               pb[r] = rnd_operand();
               ps[r] = 1'($urandom);
            end
         end
         res_ready   = (it >= 1000) ? 1'b1 : ($urandom_range(0, 99) < 65);
         req0_valid  = pv[0];
         req1_valid  = pv[1];
         req0_a      = pv[0] ? pa[0] : $urandom;
         req0_b      = pv[0] ? pb[0] : $urandom;
         req0_signed = pv[0] ? ps[0] : 1'($urandom);
         req1_a      = pv[1] ? pa[1] : $urandom;
         req1_b      = pv[1] ? pb[1] : $urandom;
         req1_signed = pv[1] ? ps[1] : 1'($urandom);
         #1;
         g0      = req0_ready;
         g1      = req1_ready;
         exp_any = (pv[0] | pv[1]) && ((outstanding == 0) || (res_valid && res_ready));
         n_vec++;
         if ((g0 | g1) !== exp_any || (g0 && g1) || (g0 && !pv[0]) || (g1 && !pv[1])) begin
            n_err++;
            $display("FAIL rnd_grant[%0d]: got %b/%b, valids %b/%b, any-grant required %b",
                     it, g0, g1, pv[0], pv[1], exp_any);
         end
         if (pv[0] && pv[1] && (g0 ^ g1)) begin
            n_vec++;
            if (g1 !== mptr) begin
               n_err++;
               $display("FAIL rnd_rr[%0d]: granted %0d, required %0d", it, g1, mptr);
            end
         end
         held = 1'b0;
         if (res_valid === 1'b1 && res_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL rnd_extra[%0d]: got result %h, required none", it, res_prod);
            end else begin
               e   = exp_q.pop_front();
               eid = exp_id_q.pop_front();
               if (res_prod !== e || res_id !== eid) begin
                  n_err++;
                  $display("FAIL rnd_result[%0d]: got %h id %b, required %h id %b",
                           it, res_prod, res_id, e, eid);
               end
            end
            outstanding--;
         end else if (res_valid === 1'b1) begin
            held      = 1'b1;
            held_prod = res_prod;
            held_id   = res_id;
         end
         if (g0 ^ g1) begin
            gid = g1 ? 1 : 0;
            exp_q.push_back(ref_mul(pa[gid], pb[gid], ps[gid]));
            exp_id_q.push_back(g1);
            mptr        = ~g1;
            outstanding++;
            acc_iter    = it;
            pv[gid]     = 1'b0;
         end
         tick();
      end
      quiet();
      n_vec++;
      if (outstanding != 0 || exp_q.size() != 0 || pv[0] || pv[1]) begin
         n_err++;
         $display("FAIL rnd_drain: outstanding %0d, queued %0d, pending %b%b, required 0/0/00",
                  outstanding, exp_q.size(), pv[1], pv[0]);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_contention();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
